risc16_btb: RTL and testbench

//  Parametrised branch target buffer with per-entry 2-bit direction counters for the RISC16 pipeline.
//  IF presents the current PC and receives a combinational predicted next PC the same cycle.
//  The resolving stage (WB/EX) reports each branch/jump outcome on the update port; the table learns from it.

---
 rtl/risc16_btb_pkg.sv | 28 ++
 rtl/risc16_btb_if.sv | 25 ++
 rtl/risc16_btb_way.sv | 77 +++++++
 rtl/risc16_btb.sv | 72 +++++++
 tb/tb_risc16_btb.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/risc16_btb_pkg.sv
// Shared types and helpers for the RISC16 branch target buffer.
// Counter encoding: values 10 and 11 predict taken.
package risc16_btb_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam int unsigned PC_STEP = 32'd2;

  // Saturating 2-bit counter step: never wraps past either end.
  function automatic ctr_t sat_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/risc16_btb_if.sv
// Lookup (IF stage) and update (resolve stage) bus of the branch target buffer.
interface risc16_btb_if #(
  parameter int XLEN = 16
);
  logic [XLEN-1:0] lk_pc;
  logic            lk_hit;
  logic            lk_taken;
  logic [XLEN-1:0] lk_next_pc;
  logic            up_valid;
  logic [XLEN-1:0] up_pc;
  logic            up_is_jump;
  logic            up_taken;
  logic [XLEN-1:0] up_target;
  logic            flush;

  modport master (
    output lk_pc, up_valid, up_pc, up_is_jump, up_taken, up_target, flush,
    input  lk_hit, lk_taken, lk_next_pc
  );

  modport slave (
    input  lk_pc, up_valid, up_pc, up_is_jump, up_taken, up_target, flush,
    output lk_hit, lk_taken, lk_next_pc
  );
endinterface

// File: rtl/risc16_btb_way.sv
// One BTB entry: storage, tag compare for lookup and update, counter training.
// Only the valid bit is reset; the payload is meaningless while valid is low.
module risc16_btb_way
  import risc16_btb_pkg::*;
#(
  parameter int XLEN      = 16,
  parameter int TAG_W     = 9,
  parameter int PRED_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  input  logic             up_sel_i,
  input  logic [TAG_W-1:0] up_tag_i,
  input  logic             up_is_jump_i,
  input  logic             up_taken_i,
  input  logic [XLEN-1:0]  up_target_i,
  output logic             hit_o,
  output logic             taken_o,
  output logic [XLEN-1:0]  target_o
);

  logic             valid_q;
  logic             jump_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  target_q;
  ctr_t             ctr_q;

  logic up_hit_s;
  logic alloc_s;

  assign up_hit_s = valid_q && (tag_q == up_tag_i);
  assign alloc_s  = up_sel_i && !up_hit_s && up_taken_i;
  assign hit_o    = valid_q && (tag_q == lk_tag_i);
  assign target_o = target_q;

  always_comb begin
    taken_o = 1'b0;
    if (!hit_o) begin
      taken_o = 1'b0;
    end else if (jump_q || (PRED_MODE == 0)) begin
      taken_o = 1'b1;
    end else begin
      taken_o = ctr_q[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (alloc_s) begin
      valid_q <= 1'b1;
    end
  end

  // Not-taken outcomes on a miss never allocate, so stale entries survive them.
  always_ff @(posedge clk) begin
    if (!flush_i && up_sel_i) begin
      if (up_hit_s) begin
        ctr_q  <= sat_next(ctr_q, up_taken_i);
        jump_q <= up_is_jump_i;
        if (up_taken_i) begin
          target_q <= up_target_i;
        end
      end else if (up_taken_i) begin
        tag_q    <= up_tag_i;
        target_q <= up_target_i;
        jump_q   <= up_is_jump_i;
        ctr_q    <= up_is_jump_i ? CTR_ST : CTR_WT;
      end
    end
  end

endmodule

// File: rtl/risc16_btb.sv
// Direct-mapped branch target buffer: index decode, per-entry ways and the
// combinational next-PC selection seen by the fetch stage.
module risc16_btb
  import risc16_btb_pkg::*;
#(
  parameter int XLEN      = 16,
  parameter int ENTRIES   = 64,
  parameter int IDX_LSB   = 1,
  parameter int PRED_MODE = 1
) (
  input  logic           clk,
  input  logic           rst,
  risc16_btb_if.slave    bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_LSB - IDX_W;

  logic [IDX_W-1:0] lk_idx_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [TAG_W-1:0] up_tag_s;

  logic            way_hit_s    [ENTRIES];
  logic            way_taken_s  [ENTRIES];
  logic [XLEN-1:0] way_target_s [ENTRIES];

  assign lk_idx_s = bus.lk_pc[IDX_LSB +: IDX_W];
  assign lk_tag_s = bus.lk_pc[XLEN-1 -: TAG_W];
  assign up_idx_s = bus.up_pc[IDX_LSB +: IDX_W];
  assign up_tag_s = bus.up_pc[XLEN-1 -: TAG_W];

  // Instruction-alignment bits below the index never reach the table.
  if (IDX_LSB > 0) begin : g_unused_lsb
    logic unused_up_lsb_s;
    assign unused_up_lsb_s = ^bus.up_pc[IDX_LSB-1:0];
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_way
    risc16_btb_way #(
      .XLEN      (XLEN),
      .TAG_W     (TAG_W),
      .PRED_MODE (PRED_MODE)
    ) u_way (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (bus.flush),
      .lk_tag_i     (lk_tag_s),
      .up_sel_i     (bus.up_valid && (up_idx_s == IDX_W'(i))),
      .up_tag_i     (up_tag_s),
      .up_is_jump_i (bus.up_is_jump),
      .up_taken_i   (bus.up_taken),
      .up_target_i  (bus.up_target),
      .hit_o        (way_hit_s[i]),
      .taken_o      (way_taken_s[i]),
      .target_o     (way_target_s[i])
    );
  end

  // Zero-latency lookup; the sequential fall-through wraps at the top of memory.
  always_comb begin
    bus.lk_hit     = way_hit_s[lk_idx_s];
    bus.lk_taken   = way_taken_s[lk_idx_s];
    bus.lk_next_pc = bus.lk_pc + XLEN'(PC_STEP);
    if (way_taken_s[lk_idx_s]) begin
      bus.lk_next_pc = way_target_s[lk_idx_s];
    end else begin
      bus.lk_next_pc = bus.lk_pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: tb/tb_risc16_btb.sv
// Directed bench for risc16_btb: each table row drives an update plus a lookup
// and checks the lookup against the table contents before that row's update.
module tb_risc16_btb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc16_btb_if #(.XLEN(16)) aif ();
  risc16_btb_if #(.XLEN(16)) bif ();

  risc16_btb #(.XLEN(16), .ENTRIES(64), .IDX_LSB(1), .PRED_MODE(1)) u_dut_a (
    .clk (clk), .rst (rst), .bus (aif.slave)
  );
  risc16_btb #(.XLEN(16), .ENTRIES(64), .IDX_LSB(1), .PRED_MODE(0)) u_dut_b (
    .clk (clk), .rst (rst), .bus (bif.slave)
  );

  typedef struct {
    string       name;
    logic        flush;
    logic        up_valid;
    logic [15:0] up_pc;
    logic        up_is_jump;
    logic        up_taken;
    logic [15:0] up_target;
    logic [15:0] lk_pc;
    logic        exp_hit;
    logic        exp_taken;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input string n, input logic fl, input logic uv,
                              input logic [15:0] upc, input logic j, input logic t,
                              input logic [15:0] tgt, input logic [15:0] lk,
                              input logic eh, input logic et, input logic [15:0] en);
    vec_t v;
    v.name = n; v.flush = fl; v.up_valid = uv; v.up_pc = upc; v.up_is_jump = j;
    v.up_taken = t; v.up_target = tgt; v.lk_pc = lk;
    v.exp_hit = eh; v.exp_taken = et; v.exp_next = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_a(input logic fl, input logic uv, input logic [15:0] upc, input logic j,
                       input logic t, input logic [15:0] tgt, input logic [15:0] lk);
    aif.flush = fl; aif.up_valid = uv; aif.up_pc = upc; aif.up_is_jump = j;
    aif.up_taken = t; aif.up_target = tgt; aif.lk_pc = lk;
  endtask

  task automatic set_b(input logic uv, input logic [15:0] upc, input logic j,
                       input logic t, input logic [15:0] tgt, input logic [15:0] lk);
    bif.flush = 1'b0; bif.up_valid = uv; bif.up_pc = upc; bif.up_is_jump = j;
    bif.up_taken = t; bif.up_target = tgt; bif.lk_pc = lk;
  endtask

  task automatic chk_a(input string n, input logic eh, input logic et, input logic [15:0] en);
    check({n, " hit"},   {15'd0, aif.lk_hit},   {15'd0, eh});
    check({n, " taken"}, {15'd0, aif.lk_taken}, {15'd0, et});
    check({n, " next"},  aif.lk_next_pc, en);
  endtask

  task automatic chk_b(input string n, input logic eh, input logic et, input logic [15:0] en);
    check({n, " hit"},   {15'd0, bif.lk_hit},   {15'd0, eh});
    check({n, " taken"}, {15'd0, bif.lk_taken}, {15'd0, et});
    check({n, " next"},  bif.lk_next_pc, en);
  endtask

  initial begin
    //              name       fl    uv    up_pc    j     t     target   lk_pc    hit   tkn   next
    vecs.push_back(mk("rst_lk",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b0, 1'b0, 16'h0042));
    vecs.push_back(mk("alloc",   1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0010, 16'h0040, 1'b0, 1'b0, 16'h0042));
    vecs.push_back(mk("wt_hit",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b1, 16'h0010));
    vecs.push_back(mk("nt1",     1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b1, 16'h0010));
    vecs.push_back(mk("nt2",     1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b0, 16'h0042));
    vecs.push_back(mk("nt3",     1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b0, 16'h0042));
    vecs.push_back(mk("snt_sat", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b1, 1'b0, 16'h0042));
    vecs.push_back(mk("nt_miss", 1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0900, 16'h0080, 1'b0, 1'b0, 16'h0082));
    vecs.push_back(mk("no_allc", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0080, 1'b0, 1'b0, 16'h0082));
    vecs.push_back(mk("alias",   1'b0, 1'b1, 16'h00C0, 1'b0, 1'b1, 16'h0300, 16'h0040, 1'b1, 1'b0, 16'h0042));
    vecs.push_back(mk("old_out", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b0, 1'b0, 16'h0042));
    vecs.push_back(mk("new_in",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h00C0, 1'b1, 1'b1, 16'h0300));
    vecs.push_back(mk("retgt",   1'b0, 1'b1, 16'h00C0, 1'b0, 1'b1, 16'h0500, 16'h00C0, 1'b1, 1'b1, 16'h0300));
    vecs.push_back(mk("retgt_v", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h00C0, 1'b1, 1'b1, 16'h0500));
    vecs.push_back(mk("jmp",     1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 16'h0100, 1'b0, 1'b0, 16'h0102));
    vecs.push_back(mk("jmp_nt1", 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b1, 16'h0200));
    vecs.push_back(mk("jmp_nt2", 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b1, 16'h0200));
    vecs.push_back(mk("jmp_nt3", 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b1, 16'h0200));
    vecs.push_back(mk("jmp_snt", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b1, 16'h0200));
    vecs.push_back(mk("flush",   1'b1, 1'b1, 16'h0140, 1'b0, 1'b1, 16'h0400, 16'h00C0, 1'b1, 1'b1, 16'h0500));
    vecs.push_back(mk("fl_c0",   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h00C0, 1'b0, 1'b0, 16'h00C2));
    vecs.push_back(mk("fl_100",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b0, 16'h0102));
    vecs.push_back(mk("fl_drop", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0140, 1'b0, 1'b0, 16'h0142));
    vecs.push_back(mk("wrap",    1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 16'h0000));

    set_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040);
    set_b(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040);
    #1;
    chk_a("in_rst", 1'b0, 1'b0, 16'h0042);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      set_a(vecs[k].flush, vecs[k].up_valid, vecs[k].up_pc, vecs[k].up_is_jump,
            vecs[k].up_taken, vecs[k].up_target, vecs[k].lk_pc);
      #1;
      chk_a(vecs[k].name, vecs[k].exp_hit, vecs[k].exp_taken, vecs[k].exp_next);
    end
    @(negedge clk);
    set_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040);

    // Pure-BTB mode: a hit predicts taken even once the counter is strong-NT.
    @(negedge clk); set_b(1'b1, 16'h0040, 1'b0, 1'b1, 16'h0010, 16'h0040);
    repeat (3) begin
      @(negedge clk); set_b(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0040);
    end
    @(negedge clk); set_b(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040);
    #1;
    chk_b("m0_snt", 1'b1, 1'b1, 16'h0010);

    // Asynchronous reset clears a learned entry without waiting for a clock.
    @(negedge clk); set_a(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0010, 16'h0040);
    @(negedge clk); set_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040);
    #1;
    chk_a("relearn", 1'b1, 1'b1, 16'h0010);
    #2 rst = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, 1'b0, 16'h0042);
    chk_b("async_rst_b", 1'b0, 1'b0, 16'h0042);

    // An update held across a clock edge under reset must be discarded.
    @(negedge clk); set_a(1'b0, 1'b1, 16'h0080, 1'b0, 1'b1, 16'h0700, 16'h0080);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0080);
    #1;
    chk_a("rst_drop", 1'b0, 1'b0, 16'h0082);
    @(negedge clk); set_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0040);
    #1;
    chk_a("post_rst", 1'b0, 1'b0, 16'h0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
